aes256_key_sched_ctrl: RTL and testbench
========================================

Name: aes256_key_sched_ctrl

Overview:
Sequencer for the combinational 256-bit key-expansion step (keyExpansion256). It loads a 256-bit cipher key and iterates the expansion step seven times, generating rCon internally. It emits the 15 AES-256 round keys, RK0..RK14, as a 128-bit stream with valid/ready backpressure. Every emitted key is also written into a local round-key store, which the encrypt and decrypt round controllers read in any order.

Parameters:
NRK, 15, number of round keys produced (fixed for AES-256; used for sizing the store and the index).
RC_INIT, 8'h01, first rCon byte; rCon word presented to the expansion step = {rc, 24'h000000}.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a schedule; sampled only in IDLE.
key_in  input  256  cipher key, word w0 in [255:224]; sampled on the accepted start.
busy  output  1  high from the cycle after an accepted start until done.
rk_valid  output  1  round key on rk_data is valid.
rk_ready  input  1  consumer accepts rk_data when rk_valid and rk_ready are both high.
rk_data  output  128  current round key, first word in [127:96].
rk_idx  output  4  index of rk_data, 0..14.
done  output  1  one-cycle pulse after RK14 is accepted.
keys_ready  output  1  sticky; all 15 keys are in the store.
rd_addr  input  4  store read address.
rd_data  output  128  store read data, registered; 1-cycle latency.

Behaviour:
- Reset (async, rst_n=0) values:
  - busy=0, rk_valid=0, rk_data=0, rk_idx=0, done=0, keys_ready=0, rd_data=0.
  - Internal: state=IDLE, cur_key=0, rc=RC_INIT, idx=0.
  - Store contents are cleared to 0.
- States: IDLE, EMIT, DONE.
- IDLE:
  - start=1 -> cur_key<=key_in, rc<=RC_INIT, idx<=0, keys_ready<=0, go to EMIT.
  - start=0 -> stay in IDLE.
- EMIT:
  - rk_valid=1 and busy=1; rk_idx=idx.
  - rk_data = cur_key[255:128] when idx is even, cur_key[127:0] when idx is odd.
  - rk_data, rk_idx and rk_valid must stay stable while rk_ready=0.
  - On handshake: store[idx]<=rk_data.
    - idx==14 -> go to DONE.
    - idx odd -> cur_key<=expansion_out(cur_key, {rc,24'h0}), rc<=rc<<1, idx<=idx+1.
    - idx even -> idx<=idx+1.
  - One key per cycle when rk_ready is held high. RK0 is on rk_data the cycle after start; RK14 is accepted at the earliest 15 cycles after start.
- Expansion: exactly one keyExpansion256 instance, driven only by cur_key and rc.
  - rc sequence: 01,02,04,08,10,20,40.
  - The 7th expansion supplies RK14 in its upper half; its lower half is never emitted.
  - rc never exceeds 8'h40 within one schedule.
- DONE: done=1 for exactly one cycle, keys_ready<=1, busy=0, rk_valid=0, then go to IDLE.
- start while busy: ignored; no state, key or rc change.
- start in the same cycle DONE is active: ignored. The next start is accepted in IDLE.
- Read port:
  - rd_data<=store[rd_addr] every cycle, independent of state.
  - rd_addr>14 -> rd_data<=0.
  - A read of the address being written in the same cycle returns the old value.
- A new schedule keeps the old store contents until they are overwritten; keys_ready=0 until that schedule completes.
- Reset mid-schedule: everything returns to reset values immediately (async); no partial done.

Test Plan:
- Reset and idle: assert rst_n=0 mid-EMIT.
  - All outputs are 0 and state is IDLE.
  - Release reset with start=0 for 10 cycles -> rk_valid stays 0.
- FIPS-197 A.3 streaming: key_in=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, rk_ready=1.
  - RK0=603deb10...857d7781; RK1=1f352c07...0914dff4.
  - RK2=9ba354118e6925afa51a8b5f2067fcde; RK3=a8b09c1a93d194cdbe49846eb75d5b9a.
  - RK14=fe4890d1e6188d0b046df344706c631e.
  - done pulses once, 16 cycles after start.
- Backpressure: same key, rk_ready toggling randomly (including 5-cycle stalls at idx 1, 7 and 13).
  - Identical key sequence; rk_data/rk_idx stable during stalls; no skipped or duplicated idx.
- Store readback: after keys_ready=1, read rd_addr 14 down to 0, then 15.
  - rd_data matches the streamed keys one cycle after each address; addr 15 -> 0.
- Start ignored while busy: pulse start with a different key_in at idx 4 and in the DONE cycle.
  - Stream stays unchanged; exactly one done; a later start in IDLE runs a fresh schedule, with keys_ready=0 until its done.
- All-zero key: key_in=0.
  - RK2=62636363626363636263636362636363 (zero-key check).
  - rc values observed at the expansion input are 01..40, then schedule ends.

Source files
------------

// File: rtl/aes256_key_sched_ctrl.sv
// rtl/aes256_key_sched_ctrl.sv - AES-256 round-key sequencer with streaming output and round-key store
// One expansion step serves each pair of emitted keys; every accepted key is mirrored into the store.

module aes256_key_sched_ctrl #(
   parameter int         NRK     = 15,
   parameter logic [7:0] RC_INIT = 8'h01
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [255:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_idx,
   output logic         done,
   output logic         keys_ready,
   input  logic [3:0]   rd_addr,
   output logic [127:0] rd_data
);
   typedef enum logic [1:0] {IDLE, EMIT, DONE} stateT;

   localparam logic [3:0] LAST_IDX = 4'(NRK - 1);

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   stateT          state, nextState;
   logic [255:0]   curKey, expKey;
   logic [7:0]     rc;
   logic [3:0]     idx;
   logic           accept;
   logic [127:0]   store [NRK];

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   // Produces the next eight words w[i+8..i+15] from w[i..i+7]
   function automatic logic [255:0] keyExpansion256(input logic [255:0] k, input logic [31:0] rCon);
      logic [31:0] t, u, n0, n1, n2, n3, n4, n5, n6, n7;
      t  = subWord({k[23:0], k[31:24]}) ^ rCon;
      n0 = k[255:224] ^ t;
      n1 = k[223:192] ^ n0;
      n2 = k[191:160] ^ n1;
      n3 = k[159:128] ^ n2;
      u  = subWord(n3);
      n4 = k[127:96]  ^ u;
      n5 = k[95:64]   ^ n4;
      n6 = k[63:32]   ^ n5;
      n7 = k[31:0]    ^ n6;
      return {n0, n1, n2, n3, n4, n5, n6, n7};
   endfunction

   assign expKey = keyExpansion256(curKey, {rc, 24'h000000});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      busy      = 1'b0;
      rk_valid  = 1'b0;
      rk_data   = '0;
      rk_idx    = '0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) nextState = EMIT;
         end
         EMIT: begin
            busy     = 1'b1;
            rk_valid = 1'b1;
            rk_idx   = idx;
            rk_data  = idx[0] ? curKey[127:0] : curKey[255:128];
            accept   = rk_ready;
            if (rk_ready && idx == LAST_IDX) nextState = DONE;
         end
         DONE: begin
            done      = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         curKey     <= '0;
         rc         <= RC_INIT;
         idx        <= '0;
         keys_ready <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            curKey     <= key_in;
            rc         <= RC_INIT;
            idx        <= '0;
            keys_ready <= 1'b0;
         end
         if (accept && idx != LAST_IDX) begin
            idx <= idx + 4'd1;
            // Odd index drains the lower half, so the next pair needs a fresh step; rc holds at its last value
            if (idx[0]) begin
               curKey <= expKey;
               if (idx != LAST_IDX - 4'd1) rc <= {rc[6:0], 1'b0};
            end
         end
         if (state == DONE) keys_ready <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NRK; i++) store[i] <= '0;
         rd_data <= '0;
      end else begin
         if (accept) store[idx] <= rk_data;
         rd_data <= (rd_addr <= LAST_IDX) ? store[rd_addr] : '0;
      end
   end

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// tb/tb_aes256_key_sched_ctrl.sv - scoreboard bench for the AES-256 round-key sequencer
// Expected keys come from an independent word-wise key expansion with an algebraically derived S-box.

module tb_aes256_key_sched_ctrl;
   localparam logic [255:0] FIPS_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] ALT_KEY  = 256'h00112233445566778899aabbccddeeff0123456789abcdeffedcba9876543210;

   typedef struct packed {
      logic [3:0]   idx;
      logic [127:0] data;
   } rkT;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [255:0] key_in = '0;
   logic         busy, rk_valid, done, keys_ready;
   logic         rk_ready = 1'b0;
   logic [127:0] rk_data, rd_data;
   logic [3:0]   rk_idx;
   logic [3:0]   rd_addr = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int doneCount = 0;
   int doneCyc = -1;

   rkT           expQ [$];
   logic [127:0] rdQ [$];
   logic [127:0] refKeys [15];
   logic [127:0] gotKeys [15];
   logic [7:0]   sbRef [256];
   logic         rdReq = 1'b0;
   logic         rdReqPrev = 1'b0;
   logic         stallPrev = 1'b0;
   logic [3:0]   stallIdx = '0;
   logic [127:0] stallData = '0;

   aes256_key_sched_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy),
      .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_idx(rk_idx),
      .done(done), .keys_ready(keys_ready), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic checkV(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = '0; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   task automatic buildSbox();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv, b;
         inv = '0;
         for (int c = 1; c < 256; c++) if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
         b = inv;
         sbRef[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subW(input logic [31:0] w);
      return {sbRef[w[31:24]], sbRef[w[23:16]], sbRef[w[15:8]], sbRef[w[7:0]]};
   endfunction

   task automatic expandRef(input logic [255:0] k);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  r;
      r = 8'h01;
      for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t = subW({t[23:0], t[31:24]}) ^ {r, 24'h000000};
            r = {r[6:0], 1'b0};
         end else if (i % 8 == 4) begin
            t = subW(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int j = 0; j < 15; j++) refKeys[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
   endtask

   always @(posedge clk) begin
      cyc       <= cyc + 1;
      rdReqPrev <= rdReq;
   end

   always @(negedge clk) begin : monitor
      rkT e;
      if (!rst_n) begin
         stallPrev = 1'b0;
      end else begin
         if (stallPrev) begin
            checkV("stall_valid", 128'(rk_valid), 128'(1));
            checkV("stall_idx", 128'(rk_idx), 128'(stallIdx));
            checkV("stall_data", rk_data, stallData);
         end
         if (rk_valid && rk_ready) begin
            if (expQ.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_key: got idx %0d data %h expected none", rk_idx, rk_data);
            end else begin
               e = expQ.pop_front();
               checkV("rk_idx", 128'(rk_idx), 128'(e.idx));
               checkV("rk_data", rk_data, e.data);
               gotKeys[rk_idx] = rk_data;
            end
         end
         stallPrev = rk_valid && !rk_ready;
         stallIdx  = rk_idx;
         stallData = rk_data;
         if (done) begin
            doneCount++;
            doneCyc = cyc;
         end
         if (rdReqPrev) begin
            if (rdQ.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_read: got %h expected none", rd_data);
            end else begin
               checkV("rd_data", rd_data, rdQ.pop_front());
            end
         end
      end
   end

   task automatic checkAllZero(input string tag);
      checkV({tag, "_busy"}, 128'(busy), 128'(0));
      checkV({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
      checkV({tag, "_rk_data"}, rk_data, 128'(0));
      checkV({tag, "_rk_idx"}, 128'(rk_idx), 128'(0));
      checkV({tag, "_done"}, 128'(done), 128'(0));
      checkV({tag, "_keys_ready"}, 128'(keys_ready), 128'(0));
      checkV({tag, "_rd_data"}, rd_data, 128'(0));
   endtask

   task automatic runSchedule(input logic [255:0] key, input bit stalls, input bit inject);
      int         startCyc, d0, budget, stallLeft;
      bit         inj4;
      logic [14:0] stalledAt;
      stallLeft = 0; inj4 = 1'b0; stalledAt = '0;
      for (int i = 0; i < 15; i++) gotKeys[i] = '0;
      expandRef(key);
      for (int i = 0; i < 15; i++) expQ.push_back(rkT'({4'(i), refKeys[i]}));
      d0 = doneCount;
      @(posedge clk); #1;
      start = 1'b1; key_in = key; startCyc = cyc;
      rk_ready = stalls ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      start = 1'b0; key_in = '1;
      checkV("busy_after_start", 128'(busy), 128'(1));
      checkV("rk0_first_valid", 128'(rk_valid), 128'(1));
      checkV("rk0_first_idx", 128'(rk_idx), 128'(0));
      checkV("keys_ready_cleared", 128'(keys_ready), 128'(0));
      budget = 0;
      while (doneCount == d0 && budget < 300) begin
         start = 1'b0;
         if (inject && rk_valid && rk_idx == 4'd4 && !inj4) begin
            start = 1'b1; key_in = ALT_KEY; inj4 = 1'b1;
         end
         if (inject && done) begin
            start = 1'b1; key_in = ALT_KEY;
         end
         if (stalls) begin
            if (rk_valid && (rk_idx == 4'd1 || rk_idx == 4'd7 || rk_idx == 4'd13) && !stalledAt[rk_idx]) begin
               stalledAt[rk_idx] = 1'b1;
               stallLeft = 5;
            end
            if (stallLeft > 0) begin
               rk_ready = 1'b0;
               stallLeft--;
            end else begin
               rk_ready = 1'($urandom_range(0, 1));
            end
         end
         @(posedge clk); #1;
         budget++;
      end
      start = 1'b0;
      if (budget >= 300) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done", budget);
      end
      if (!stalls) checkV("done_latency", 128'(doneCyc - startCyc), 128'(16));
      rk_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      checkV("done_once", 128'(doneCount - d0), 128'(1));
      checkV("keys_ready_set", 128'(keys_ready), 128'(1));
      checkV("idle_valid", 128'(rk_valid), 128'(0));
      checkV("idle_busy", 128'(busy), 128'(0));
      checkV("keys_consumed", 128'(expQ.size()), 128'(0));
   endtask

   task automatic readback();
      for (int a = 14; a >= 0; a--) begin
         @(posedge clk); #1;
         rd_addr = 4'(a); rdReq = 1'b1;
         rdQ.push_back(refKeys[a]);
      end
      @(posedge clk); #1;
      rd_addr = 4'd15;
      rdQ.push_back(128'(0));
      @(posedge clk); #1;
      rdReq = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      checkV("reads_consumed", 128'(rdQ.size()), 128'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      buildSbox();
      #2 rst_n = 1'b0;
      #1 checkAllZero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Reset in the middle of a schedule
      expandRef(FIPS_KEY);
      for (int i = 0; i < 15; i++) expQ.push_back(rkT'({4'(i), refKeys[i]}));
      @(posedge clk); #1;
      start = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1 checkAllZero("mid_reset");
      expQ.delete();
      rk_ready = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checkV("post_reset_valid", 128'(rk_valid), 128'(0));
      end
      checkV("no_partial_done", 128'(doneCount), 128'(0));

      // Streaming with FIPS-197 key
      runSchedule(FIPS_KEY, 1'b0, 1'b0);
      checkV("fips_rk0", gotKeys[0], 128'h603deb1015ca71be2b73aef0857d7781);
      checkV("fips_rk1", gotKeys[1], 128'h1f352c073b6108d72d9810a30914dff4);
      checkV("fips_rk2", gotKeys[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
      checkV("fips_rk3", gotKeys[3], 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
      checkV("fips_rk14", gotKeys[14], 128'hfe4890d1e6188d0b046df344706c631e);
      readback();

      // Backpressure
      runSchedule(FIPS_KEY, 1'b1, 1'b0);
      checkV("bp_rk14", gotKeys[14], 128'hfe4890d1e6188d0b046df344706c631e);

      // Start pulses while busy and during the done cycle
      runSchedule(FIPS_KEY, 1'b0, 1'b1);
      checkV("inj_rk14", gotKeys[14], 128'hfe4890d1e6188d0b046df344706c631e);

      // Fresh schedule with the all-zero key
      runSchedule(256'h0, 1'b0, 1'b0);
      checkV("zero_rk0", gotKeys[0], 128'h0);
      checkV("zero_rk2", gotKeys[2], 128'h62636363626363636263636362636363);
      checkV("zero_rk3", gotKeys[3], 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb);
      checkV("zero_rk4", gotKeys[4], 128'h6f6c6ccf0d0f0fac6f6c6ccf0d0f0fac);
      readback();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
